// File: rtl/kama_pkg.sv
// Shared types for the elastic pipeline: per-slot occupancy state and a
// helper that turns a slot state into the number of beats it holds.
package kama_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // Beats held by one slot in a given state (main only, or main + skid).
  function automatic logic [1:0] held_count(skid_state_e s);
    case (s)
      BUSY:    held_count = 2'd1;
      FULL:    held_count = 2'd2;
      default: held_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/skid_slot.sv
// One elastic stage: a main register feeding the output and a skid register
// that catches the beat accepted in the same cycle the downstream stalls.
// Upstream ready comes straight from a flop, so no ready path crosses a stage.
module skid_slot
  import kama_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       held
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             ready_q, ready_d;
  logic             accept;
  logic             drain;

  // Next-state and datapath: order is main (oldest) then skid.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    accept  = in_valid & ready_q;
    drain   = (state_q != EMPTY) & out_ready;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = BUSY;
          main_d  = in_data;
        end
      end
      BUSY: begin
        if (accept && drain) begin
          main_d = in_data;
        end else if (accept) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
    // Ready for the next cycle is known now, so it can be registered.
    ready_d = (state_d != FULL);
  end

  // State, data and ready registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign held      = held_count(state_q);

endmodule

// File: rtl/elastic_pipe.sv
// Elastic pipeline of STAGES skid slots in series. Each slot registers its
// own ready, giving STAGES cycles of latency, full throughput and a capacity
// of 2*STAGES beats. Occupancy is the sum of what every slot holds.
module elastic_pipe
  import kama_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_data,
  output logic [$clog2(2*STAGES+1)-1:0]    occupancy
);

  localparam int OCC_W = $clog2(2*STAGES+1);

  // Link signals: index i is the input of slot i, index STAGES the pipe output.
  logic             link_valid [0:STAGES];
  logic             link_ready [0:STAGES];
  logic [WIDTH-1:0] link_data  [0:STAGES];
  logic [1:0]       slot_held  [0:STAGES-1];
  logic [OCC_W-1:0] occ_sum;

  assign link_valid[0]      = in_valid;
  assign link_data[0]       = in_data;
  assign in_ready           = link_ready[0];
  assign out_valid          = link_valid[STAGES];
  assign out_data           = link_data[STAGES];
  assign link_ready[STAGES] = out_ready;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_slot
      skid_slot #(
        .WIDTH (WIDTH)
      ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (link_valid[gi]),
        .in_ready  (link_ready[gi]),
        .in_data   (link_data[gi]),
        .out_valid (link_valid[gi+1]),
        .out_ready (link_ready[gi+1]),
        .out_data  (link_data[gi+1]),
        .held      (slot_held[gi])
      );
    end
  endgenerate

  // Total held beats across all slots.
  always_comb begin
    occ_sum = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_sum = occ_sum + OCC_W'(slot_held[i]);
    end
  end

  assign occupancy = occ_sum;

endmodule

// File: doc/elastic_pipe.md
ELASTIC_PIPE -- requirements
Module: elastic_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload bit width (>=1).
REQ-002 SHALL have parameter STAGES, default 2, number of pipeline stages (>=1).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush  input  1  synchronous discard of all held beats.
REQ-006 SHALL have port in_valid  input  1  upstream beat present.
REQ-007 SHALL have port in_ready  output  1  pipe can accept a beat.
REQ-008 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-009 SHALL have port out_valid  output  1  downstream beat present.
REQ-010 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-011 SHALL have port out_data  output  WIDTH  downstream payload.
REQ-012 SHALL have port occupancy  output  $clog2(2*STAGES+1)  count of held beats.

Function
REQ-013 SHALL transfer a beat on a port when valid and ready are both high at a rising edge.
REQ-014 SHALL implement each stage as a main register plus a skid register; total capacity 2*STAGES beats.
REQ-015 SHALL run per-stage state machine EMPTY (none held), BUSY (main held), FULL (main+skid held).
REQ-016 SHALL transition EMPTY->BUSY on accept; BUSY->FULL on accept without drain; BUSY->EMPTY on drain without accept; BUSY->BUSY on simultaneous accept+drain (main loads new beat); FULL->BUSY on drain (skid moves to main).
REQ-017 SHALL drive each stage's upstream ready directly from a register (skid empty), never combinationally from out_ready.
REQ-018 SHALL give latency of exactly STAGES cycles from input accept to out_valid with no backpressure, and throughput of one beat per cycle sustained.
REQ-019 SHALL preserve beat order with no loss or duplication under any out_ready pattern.
REQ-020 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, on flush=1, set all stages EMPTY and occupancy 0 at the next edge; a beat offered in the flush cycle is dropped; an output transfer completing in the flush cycle counts as delivered.
REQ-022 SHALL update occupancy each edge as previous +accepted -delivered, saturating impossible by construction; equals number of held beats.
REQ-023 SHALL keep in_ready=1 whenever stage 0 skid register is empty, including when full-downstream stages stall.

Reset
REQ-024 SHALL, while rst=1, force all stages EMPTY, out_valid=0, in_ready=1 after release, occupancy=0, out_data=0, independent of clk.
REQ-025 SHALL clear all data registers (main and skid) to 0 on reset.
REQ-026 SHALL accept the first beat on the first rising edge after rst deasserts.

Structure
REQ-027 SHALL place enum skid_state_e {EMPTY, BUSY, FULL} in shared package kama_pkg.
REQ-028 SHALL implement one stage as sub-module skid_slot (params WIDTH; ports clk, rst, flush, valid/ready/data in and out), instantiated STAGES times via generate.
REQ-029 SHALL compute occupancy in the top level from per-stage held counts.

Verification (WIDTH=8, STAGES=2 unless stated)
REQ-030 SHALL cover stream 0x01..0x10 with out_ready=1 -> first out_valid 2 cycles after first accept, one beat per cycle in order, occupancy steady at 2.
REQ-031 SHALL cover out_ready=0 with continuous in_valid -> exactly 4 beats accepted, in_ready=0 afterward, occupancy=4; then out_ready=1 -> 4 beats drained in order, occupancy returns to 0.
REQ-032 SHALL cover flush with occupancy=3 and in_valid=1 (data 0xAA) -> next cycle out_valid=0, occupancy=0, in_ready=1; 0xAA never emitted.
REQ-033 SHALL cover asynchronous rst mid-stream between edges -> out_valid=0, out_data=0x00, occupancy=0 immediately, without a clock edge.
REQ-034 SHALL cover out_ready toggling 1,0,1,0 with 0x10..0x1F input -> all 16 beats delivered once in order, out_data stable during each stall cycle.
REQ-035 SHALL cover WIDTH=1, STAGES=1 -> capacity 2, latency 1, same ordering and flush behaviour.
